cache_write_buffer: RTL and testbench

//  Posted-write buffer between the write-through, no-write-allocate data cache and main data memory.

---
 rtl/cache_wb_pkg.sv | 18 +
 rtl/cache_wb_fwd_match.sv | 34 +++
 rtl/cache_write_buffer.sv | 163 ++++++++++++++++
 tb/tb_cache_write_buffer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_wb_pkg.sv
// Shared types and default widths for the cache write buffer slice.
package cache_wb_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic {
      WB_IDLE,
      WB_ISSUE
   } wb_state_e;

   typedef struct packed {
      logic                  valid;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/cache_wb_fwd_match.sv
// DEPTH-way address compare with newest-first priority, counted backwards from wr_ptr.
module cache_wb_fwd_match
   import cache_wb_pkg::*;
#(
   parameter  int unsigned DEPTH  = 4,
   parameter  int unsigned ADDR_W = ADDR_W_DEF,
   localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]  valid,
   input  logic [DEPTH-1:0]  excl,
   input  logic [ADDR_W-1:0] addr [DEPTH],
   input  logic [PTR_W-1:0]  wr_ptr,
   input  logic [ADDR_W-1:0] key,
   output logic              hit,
   output logic [PTR_W-1:0]  idx
);

   logic [PTR_W-1:0] slot;

   // Walk oldest to newest so a later (newer) match overrides an earlier one.
   always_comb begin
      hit  = 1'b0;
      idx  = '0;
      slot = '0;
      for (int unsigned k = DEPTH; k > 0; k--) begin
         slot = wr_ptr - PTR_W'(k);
         if (valid[slot] && !excl[slot] && (addr[slot] == key)) begin
            hit = 1'b1;
            idx = slot;
         end
      end
   end

endmodule

// File: rtl/cache_write_buffer.sv
// Posted-write buffer between the write-through data cache and main memory, with read forwarding.
// Optional in-place store coalescing is enabled by defining CACHE_WB_COALESCE_EN.
module cache_write_buffer
   import cache_wb_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_data,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic              flush,
   output logic              empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   wb_state_e         state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];

   logic              issuing;
   logic              wr_fire;
   logic              push_alloc;
   logic              pop;
   logic              fwd_hit_i;
   logic [PTR_W-1:0]  fwd_idx;
   logic [DEPTH-1:0]  no_excl;

   assign issuing = (state_q == WB_ISSUE);
   assign no_excl = '0;
   assign wr_fire = wr_valid && wr_ready;

   cache_wb_fwd_match #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fwd (
      .valid  (valid_q),
      .excl   (no_excl),
      .addr   (addr_q),
      .wr_ptr (wr_ptr_q),
      .key    (rd_addr),
      .hit    (fwd_hit_i),
      .idx    (fwd_idx)
   );

`ifdef CACHE_WB_COALESCE_EN
   logic              cm_hit;
   logic [PTR_W-1:0]  cm_idx;
   logic [DEPTH-1:0]  head_excl;
   logic              coalesce;

   // The head is frozen while its write is in flight, so it is never a coalesce target.
   always_comb begin
      head_excl = '0;
      if (issuing) head_excl[rd_ptr_q] = 1'b1;
   end

   cache_wb_fwd_match #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_coal (
      .valid  (valid_q),
      .excl   (head_excl),
      .addr   (addr_q),
      .wr_ptr (wr_ptr_q),
      .key    (wr_addr),
      .hit    (cm_hit),
      .idx    (cm_idx)
   );

   assign wr_ready   = !flush && ((count_q < CNT_W'(DEPTH)) || cm_hit);
   assign coalesce   = wr_fire && cm_hit;
   assign push_alloc = wr_fire && !cm_hit;
`else
   assign wr_ready   = !flush && (count_q < CNT_W'(DEPTH));
   assign push_alloc = wr_fire;
`endif

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      valid_d  = valid_q;
      addr_d   = addr_q;
      data_d   = data_q;
      pop      = 1'b0;

      if (push_alloc) begin
         valid_d[wr_ptr_q] = 1'b1;
         addr_d[wr_ptr_q]  = wr_addr;
         data_d[wr_ptr_q]  = wr_data;
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
`ifdef CACHE_WB_COALESCE_EN
      if (coalesce) data_d[cm_idx] = wr_data;
`endif

      case (state_q)
         WB_IDLE:  if (count_q != '0) state_d = WB_ISSUE;
         WB_ISSUE: if (mem_ack) pop = 1'b1;
         default:  state_d = WB_IDLE;
      endcase

      if (pop) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      end

      count_d = count_q + CNT_W'(push_alloc) - CNT_W'(pop);
      // A store landing in the same cycle as the last pop keeps the drain going back-to-back.
      if (pop && (count_d == '0)) state_d = WB_IDLE;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= WB_IDLE;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         valid_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         valid_q  <= valid_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

   assign mem_req   = issuing;
   assign mem_addr  = issuing ? addr_q[rd_ptr_q] : '0;
   assign mem_wdata = issuing ? data_q[rd_ptr_q] : '0;
   assign fwd_hit   = fwd_hit_i;
   assign fwd_data  = fwd_hit_i ? data_q[fwd_idx] : '0;
   assign empty     = (count_q == '0) && (state_q == WB_IDLE);

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed self-checking bench for cache_write_buffer (DEPTH=4, ADDR_W=8, DATA_W=32).
module tb_cache_write_buffer;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 32;

`ifdef CACHE_WB_COALESCE_EN
   localparam int T3_COUNT = 1;
`else
   localparam int T3_COUNT = 2;
`endif

   logic              clk      = 1'b0;
   logic              rstn     = 1'b1;
   logic              wr_valid = 1'b0;
   logic [ADDR_W-1:0] wr_addr  = '0;
   logic [DATA_W-1:0] wr_data  = '0;
   logic              wr_ready;
   logic [ADDR_W-1:0] rd_addr  = '0;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack  = 1'b0;
   logic              flush    = 1'b0;
   logic              empty;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   logic [ADDR_W-1:0] dr_addr [$];
   logic [DATA_W-1:0] dr_data [$];
   int                dr_cyc  [$];
   logic [DATA_W-1:0] mem_model [256];

   cache_write_buffer #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .rd_addr   (rd_addr),
      .fwd_hit   (fwd_hit),
      .fwd_data  (fwd_data),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .flush     (flush),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Memory side: a write is taken when req and ack are both high at the coming edge.
   always @(negedge clk) begin
      if (rstn && mem_req && mem_ack) begin
         dr_addr.push_back(mem_addr);
         dr_data.push_back(mem_wdata);
         dr_cyc.push_back(cycle);
         mem_model[mem_addr] <= mem_wdata;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input logic v, input logic [7:0] a, input logic [31:0] d);
      wr_valid = v;
      wr_addr  = a;
      wr_data  = d;
   endtask

   task automatic clear_log();
      dr_addr.delete();
      dr_data.delete();
      dr_cyc.delete();
   endtask

   initial begin
      // ---- reset state
      #1 rstn = 1'b0;
      #1;
      chk1 ("rst_wr_ready", wr_ready, 1'b1);
      chk1 ("rst_mem_req", mem_req, 1'b0);
      chk8 ("rst_mem_addr", mem_addr, 8'h00);
      chk32("rst_mem_wdata", mem_wdata, 32'h0);
      chk1 ("rst_fwd_hit", fwd_hit, 1'b0);
      chk32("rst_fwd_data", fwd_data, 32'h0);
      chk1 ("rst_empty", empty, 1'b1);
      cyc();
      cyc();
      rstn = 1'b1;
      #1;

      // ---- 1: single store, ack two cycles after request
      set_wr(1'b1, 8'h12, 32'hDEADBEEF);
      rd_addr = 8'h12;
      #1;
      chk1("t1_wr_ready", wr_ready, 1'b1);
      chk1("t1_same_cycle_no_fwd", fwd_hit, 1'b0);
      cyc();
      wr_valid = 1'b0;
      #1;
      chk1 ("t1_req_idle", mem_req, 1'b0);
      chk1 ("t1_fwd_hit", fwd_hit, 1'b1);
      chk32("t1_fwd_data", fwd_data, 32'hDEADBEEF);
      chk1 ("t1_not_empty", empty, 1'b0);
      cyc();
      chk1 ("t1_req", mem_req, 1'b1);
      chk8 ("t1_addr", mem_addr, 8'h12);
      chk32("t1_data", mem_wdata, 32'hDEADBEEF);
      cyc();
      chk1 ("t1_req_hold", mem_req, 1'b1);
      chk8 ("t1_addr_hold", mem_addr, 8'h12);
      chk32("t1_data_hold", mem_wdata, 32'hDEADBEEF);
      mem_ack = 1'b1;
      #1;
      chk1("t1_fwd_ack_cycle", fwd_hit, 1'b1);
      chk1("t1_not_empty_ack", empty, 1'b0);
      cyc();
      mem_ack = 1'b0;
      #1;
      chk1 ("t1_req_done", mem_req, 1'b0);
      chk1 ("t1_empty", empty, 1'b1);
      chk1 ("t1_fwd_gone", fwd_hit, 1'b0);
      chk32("t1_fwd_data_zero", fwd_data, 32'h0);

      // ---- 2: fill, stall, drain in order
      for (int i = 0; i < 4; i++) begin
         set_wr(1'b1, 8'(32'h20 + i), 32'h100 + i);
         #1;
         chk1("t2_ready_fill", wr_ready, 1'b1);
         cyc();
      end
      set_wr(1'b1, 8'h24, 32'h104);
      #1;
      chk1 ("t2_full_not_ready", wr_ready, 1'b0);
      chk1 ("t2_req", mem_req, 1'b1);
      chk8 ("t2_head0_addr", mem_addr, 8'h20);
      chk32("t2_head0_data", mem_wdata, 32'h100);
      cyc();
      chk1("t2_stall_ready", wr_ready, 1'b0);
      chk8("t2_head0_hold", mem_addr, 8'h20);
      mem_ack = 1'b1;
      #1;
      chk1("t2_ready_in_ack_cycle", wr_ready, 1'b0);
      cyc();
      mem_ack = 1'b0;
      #1;
      chk1("t2_ready_after_ack", wr_ready, 1'b1);
      chk8("t2_head1_addr", mem_addr, 8'h21);
      cyc();
      wr_valid = 1'b0;
      #1;
      chki("t2_count_refull", int'(dut.count_q), 4);
      mem_ack = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk8 ("t2_order_addr", mem_addr, 8'(32'h20 + i));
         chk32("t2_order_data", mem_wdata, 32'h100 + i);
         cyc();
      end
      mem_ack = 1'b0;
      #1;
      chk1("t2_empty", empty, 1'b1);

      // ---- 3: duplicate address, newest wins
      clear_log();
      set_wr(1'b1, 8'h05, 32'h1);
      cyc();
      set_wr(1'b1, 8'h05, 32'h2);
      cyc();
      wr_valid = 1'b0;
      rd_addr  = 8'h05;
      #1;
      chk1 ("t3_fwd_hit", fwd_hit, 1'b1);
      chk32("t3_fwd_newest", fwd_data, 32'h2);
      chki ("t3_count", int'(dut.count_q), T3_COUNT);
      mem_ack = 1'b1;
      for (int n = 0; n < 10 && !empty; n++) cyc();
      mem_ack = 1'b0;
      #1;
      chk1 ("t3_drained", empty, 1'b1);
      chk32("t3_mem_final", mem_model[5], 32'h2);
      chki ("t3_writes", dr_addr.size(), T3_COUNT);

      // ---- 4: ack tied high, back-to-back stores with pointer wrap
      clear_log();
      mem_ack = 1'b1;
      for (int i = 0; i < 6; i++) begin
         set_wr(1'b1, 8'(32'h40 + i), 32'h200 + i);
         #1;
         chk1("t4_ready", wr_ready, 1'b1);
         cyc();
      end
      wr_valid = 1'b0;
      for (int n = 0; n < 20 && !empty; n++) cyc();
      mem_ack = 1'b0;
      #1;
      chk1("t4_drained", empty, 1'b1);
      chki("t4_writes", dr_addr.size(), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < dr_addr.size()) begin
            chk8 ("t4_addr", dr_addr[i], 8'(32'h40 + i));
            chk32("t4_data", dr_data[i], 32'h200 + i);
         end
      end
      if (dr_cyc.size() == 6) chki("t4_one_pop_per_cycle", dr_cyc[5] - dr_cyc[0], 5);

      // ---- 5: flush with three pending stores
      clear_log();
      for (int i = 0; i < 3; i++) begin
         set_wr(1'b1, 8'(32'h60 + i), 32'h300 + i);
         cyc();
      end
      set_wr(1'b1, 8'h63, 32'h363);
      flush = 1'b1;
      #1;
      chk1("t5_ready_blocked", wr_ready, 1'b0);
      chk1("t5_not_empty", empty, 1'b0);
      mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk1("t5_ready_hold", wr_ready, 1'b0);
         chk1("t5_empty", empty, (i == 2));
      end
      mem_ack  = 1'b0;
      wr_valid = 1'b0;
      flush    = 1'b0;
      #1;
      chk1("t5_ready_released", wr_ready, 1'b1);
      chki("t5_writes", dr_addr.size(), 3);
      if (dr_addr.size() == 3) chk8("t5_last_addr", dr_addr[2], 8'h62);

      // ---- 6: async reset in the middle of a drain
      set_wr(1'b1, 8'h70, 32'h700);
      cyc();
      set_wr(1'b1, 8'h71, 32'h701);
      cyc();
      wr_valid = 1'b0;
      #1;
      chk1("t6_req_before", mem_req, 1'b1);
      #1 rstn = 1'b0;
      #1;
      chk1 ("t6_req_dropped", mem_req, 1'b0);
      chk8 ("t6_mem_addr", mem_addr, 8'h00);
      chk32("t6_mem_wdata", mem_wdata, 32'h0);
      chk1 ("t6_wr_ready", wr_ready, 1'b1);
      chk1 ("t6_empty", empty, 1'b1);
      for (int a = 0; a < 256; a++) begin
         rd_addr = 8'(a);
         #1;
         chk1("t6_no_fwd", fwd_hit, 1'b0);
      end
      chk32("t6_fwd_data", fwd_data, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      cyc();
      cyc();
      chk1("t6_req_after", mem_req, 1'b0);
      chk1("t6_empty_after", empty, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
